// File: rtl/fetch_unit.sv
// PC register and instruction-fetch sequencer for the single-cycle core:
// fetches over a req/ack port, holds one execute window, then commits next PC.
module fetch_unit #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  input  logic            ecall,
  input  logic            exec_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_err,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            instr_valid,
  output logic            halted,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic [63:0]     instret
);

  typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] target;
  logic            retire;
  logic            misaligned;
  logic            fetch_ok;
  logic            fetch_bad;

  assign pc_plus4  = pc + XLEN'(4);
  assign imem_addr = pc;

  always_comb begin
    case (pc_src)
      2'b00:   target = pc_plus4;
      2'b01:   target = pc + imm_ext;
      default: target = {alu_result[XLEN-1:1], 1'b0};
    endcase
  end

  assign misaligned = target[1];
  assign retire     = (state == EXEC) && !exec_stall;
  assign fetch_ok   = (state == FETCH) && imem_ack && !imem_err;
  assign fetch_bad  = (state == FETCH) && imem_ack && imem_err;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    state_nx    = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      BOOT:  state_nx = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nx = imem_err ? HALT : EXEC;
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!exec_stall) state_nx = (ecall || misaligned) ? HALT : FETCH;
      end
      default: state_nx = HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      instret     <= '0;
    end else begin
      if (fetch_ok) instr <= imem_rdata;
      if (fetch_bad) begin
        fault       <= 1'b1;
        fault_cause <= 2'b01;
        halted      <= 1'b1;
      end
      if (retire) begin
        instret <= instret + 64'd1;
        // ecall wins over the misaligned-target check; pc stays on the halting instruction
        if (ecall) begin
          halted <= 1'b1;
        end else if (misaligned) begin
          fault       <= 1'b1;
          fault_cause <= 2'b10;
          halted      <= 1'b1;
        end else begin
          pc    <= target;
          instr <= NOP_INSTR;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with RESET_PC = 0x1000.
module tb_fetch_unit;

  localparam int          XLEN = 64;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] WORD = 32'hAAAA_0001;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      pc_src = 2'b00;
  logic [XLEN-1:0] imm_ext = '0;
  logic [XLEN-1:0] alu_result = '0;
  logic            ecall = 1'b0;
  logic            exec_stall = 1'b0;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [31:0]     imem_rdata = WORD;
  logic            imem_err = 1'b0;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            instr_valid;
  logic            halted;
  logic            fault;
  logic [1:0]      fault_cause;
  logic [63:0]     instret;

  int total = 0;
  int bad = 0;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(64'h1000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .imm_ext(imm_ext),
    .alu_result(alu_result), .ecall(ecall), .exec_stall(exec_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err), .instr(instr), .pc(pc),
    .pc_plus4(pc_plus4), .instr_valid(instr_valid), .halted(halted),
    .fault(fault), .fault_cause(fault_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its BOOT cycle, 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    pc_src = 2'b00; imm_ext = '0; alu_result = '0;
    ecall = 1'b0; exec_stall = 1'b0;
    imem_ack = 1'b0; imem_err = 1'b0; imem_rdata = WORD;
    step();
    reset = 1'b0;
  endtask

  // From BOOT: run the first instruction as a JALR to 0x2001, ending in FETCH at 0x2000.
  task automatic goto_2000();
    do_reset();
    imem_ack = 1'b1;
    step();
    step();
    pc_src = 2'b11; alu_result = 64'h2001;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pc !== 64'h1000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 64'h1000); end
    total++; if (instr !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    total++; if ({halted, fault, fault_cause} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {halted, fault, fault_cause}); end
    total++; if (instret !== 64'd0) begin bad++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    total++; if (pc_plus4 !== 64'h1004) begin bad++; $display("FAIL reset_pc_plus4 got=%h exp=%h", pc_plus4, 64'h1004); end
  endtask

  task automatic test_sequential();
    logic [XLEN-1:0] exp_pc;
    do_reset();
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 64'h1000 + 64'(4 * i);
      step();
      total++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin bad++; $display("FAIL seq_fetch%0d got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, exp_pc); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL seq_fetch_valid%0d got=%b exp=0", i, instr_valid); end
      step();
      total++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL seq_exec%0d got valid=%b req=%b exp valid=1 req=0", i, instr_valid, imem_req); end
      total++; if (instr !== WORD || pc !== exp_pc) begin bad++; $display("FAIL seq_exec_data%0d got instr=%h pc=%h exp instr=%h pc=%h", i, instr, pc, WORD, exp_pc); end
    end
    step();
    total++; if (instret !== 64'd3) begin bad++; $display("FAIL seq_instret got=%0d exp=3", instret); end
    total++; if (pc !== 64'h100C || instr !== NOP) begin bad++; $display("FAIL seq_next got pc=%h instr=%h exp pc=%h instr=%h", pc, instr, 64'h100C, NOP); end
  endtask

  task automatic test_wait_ack();
    do_reset();
    imem_ack = 1'b1;
    step();
    step();
    imem_ack = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) imem_ack = 1'b1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 64'h1004) begin bad++; $display("FAIL wait_req%0d got req=%b addr=%h exp req=1 addr=%h", k, imem_req, imem_addr, 64'h1004); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL wait_valid%0d got=%b exp=0", k, instr_valid); end
      step();
    end
    imem_ack = 1'b0;
    total++; if (instr_valid !== 1'b1 || pc !== 64'h1004) begin bad++; $display("FAIL wait_exec got valid=%b pc=%h exp valid=1 pc=%h", instr_valid, pc, 64'h1004); end
  endtask

  task automatic test_branch();
    goto_2000();
    total++; if (imem_addr !== 64'h2000) begin bad++; $display("FAIL jalr_2000 got=%h exp=%h", imem_addr, 64'h2000); end
    step();
    pc_src = 2'b01; imm_ext = -64'sd8;
    total++; if (instr_valid !== 1'b1 || pc !== 64'h2000) begin bad++; $display("FAIL br_exec got valid=%b pc=%h exp valid=1 pc=%h", instr_valid, pc, 64'h2000); end
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 64'h1FF8) begin bad++; $display("FAIL br_neg got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, 64'h1FF8); end
    step();
    pc_src = 2'b11; alu_result = 64'h3005;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 64'h3004) begin bad++; $display("FAIL jalr_lsb got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, 64'h3004); end
    total++; if (fault !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL br_noflags got fault=%b halted=%b exp 0 0", fault, halted); end
  endtask

  task automatic test_misaligned();
    goto_2000();
    step();
    pc_src = 2'b01; imm_ext = 64'h6;
    step();
    total++; if ({halted, fault, fault_cause} !== 4'b1110) begin bad++; $display("FAIL mis_flags got=%b exp=1110", {halted, fault, fault_cause}); end
    total++; if (pc !== 64'h2000) begin bad++; $display("FAIL mis_pc got=%h exp=%h", pc, 64'h2000); end
    total++; if (instret !== 64'd2) begin bad++; $display("FAIL mis_instret got=%0d exp=2", instret); end
    step();
    step();
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL mis_quiet got req=%b valid=%b exp 0 0", imem_req, instr_valid); end
  endtask

  task automatic test_ecall_stall();
    int valid_cycles = 0;
    do_reset();
    imem_ack = 1'b1;
    step();
    step();
    ecall = 1'b1; exec_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) exec_stall = 1'b0;
      if (instr_valid === 1'b1 && pc === 64'h1000) valid_cycles++;
      step();
    end
    ecall = 1'b0;
    total++; if (valid_cycles !== 3) begin bad++; $display("FAIL ecall_window got=%0d exp=3", valid_cycles); end
    total++; if (halted !== 1'b1 || fault !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL ecall_halt got halted=%b fault=%b valid=%b exp 1 0 0", halted, fault, instr_valid); end
    step();
    total++; if (instret !== 64'd1 || pc !== 64'h1000) begin bad++; $display("FAIL ecall_frozen got instret=%0d pc=%h exp 1 %h", instret, pc, 64'h1000); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL ecall_noreq got=%b exp=0", imem_req); end
  endtask

  task automatic test_fetch_err();
    do_reset();
    imem_ack = 1'b1; imem_err = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    imem_err = 1'b0;
    total++; if ({halted, fault, fault_cause} !== 4'b1101) begin bad++; $display("FAIL err_flags got=%b exp=1101", {halted, fault, fault_cause}); end
    total++; if (instr !== NOP || instr_valid !== 1'b0) begin bad++; $display("FAIL err_instr got instr=%h valid=%b exp %h 0", instr, instr_valid, NOP); end
    step();
    total++; if (imem_req !== 1'b0 || instret !== 64'd0) begin bad++; $display("FAIL err_frozen got req=%b instret=%0d exp 0 0", imem_req, instret); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    step();
    step();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL mid_pre_req got=%b exp=1", imem_req); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mid_async_drop got=%b exp=0", imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    reset = 1'b0;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 64'h1000 || instr_valid !== 1'b0) begin bad++; $display("FAIL mid_restart got req=%b addr=%h valid=%b exp 1 %h 0", imem_req, imem_addr, instr_valid, 64'h1000); end
    step();
    total++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5678 || pc !== 64'h1000) begin bad++; $display("FAIL mid_exec got valid=%b instr=%h pc=%h exp 1 12345678 %h", instr_valid, instr, pc, 64'h1000); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_ack();
    test_branch();
    test_misaligned();
    test_ecall_stall();
    test_fetch_err();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
PC register and instruction-fetch sequencer for the single-cycle core. It sits directly upstream of the decode/control path. It fetches one 32-bit instruction per step over a req/ack instruction-memory port and presents it, with its PC, for one execute window. It then commits the next PC chosen by the control unit's PCSrc, and halts on ECALL or on a fetch fault.

Parameters:
XLEN, 64, datapath/PC width.
RESET_PC, 64'h0, PC loaded on reset.
NOP_INSTR, 32'h00000013, value driven on instr when no valid instruction is held.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
pc_src  in  2  PCSrc from control unit: 00 seq, 01 pc+imm, 1x jalr target
imm_ext  in  XLEN  sign-extended immediate for branch/JAL target
alu_result  in  XLEN  JALR target (rs1+imm)
ecall  in  1  ECALL decoded for the current instruction
exec_stall  in  1  datapath needs more cycles to finish the current instruction
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address (equals pc)
imem_ack  in  1  fetch data valid
imem_rdata  in  32  fetched instruction
imem_err  in  1  fetch bus error, qualified by imem_ack
instr  out  32  current instruction
pc  out  XLEN  PC of current instruction
pc_plus4  out  XLEN  pc+4, used for link writeback
instr_valid  out  1  execute window; the datapath commits state only while high
halted  out  1  sticky halt
fault  out  1  sticky fault
fault_cause  out  2  00 none, 01 fetch bus error, 10 misaligned target
instret  out  64  retired-instruction counter

Behaviour:
- Reset (asynchronous, immediate, any state):
  - state=BOOT, pc=RESET_PC, instr=NOP_INSTR.
  - imem_req=0, instr_valid=0, halted=0, fault=0, fault_cause=00, instret=0.
- FSM states: BOOT, FETCH, EXEC, HALT.
- BOOT: one cycle with no request; always goes to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - Zero-wait ack in the same cycle as req is legal.
  - On ack with imem_err=0: instr<=imem_rdata, go to EXEC.
  - On ack with imem_err=1: fault=1, fault_cause=01, go to HALT; instr stays NOP_INSTR.
  - With no ack, stay in FETCH.
- EXEC:
  - instr_valid=1 and imem_req=0.
  - If exec_stall=1, stay in EXEC; pc and instr are held.
  - If exec_stall=0, the instruction retires this cycle: instret+1 (wraps mod 2^64).
  - Next-PC selection:
    - pc_src 00 -> pc+4.
    - pc_src 01 -> pc+imm_ext.
    - pc_src 10 or 11 -> {alu_result[XLEN-1:1],1'b0}.
    - All adds are mod 2^XLEN; wrap-around is silent.
  - Retire outcomes:
    - ecall=1 -> halted=1, go to HALT; pc unchanged.
    - Selected target has bit1=1 -> fault=1, fault_cause=10, halted=1, go to HALT; pc unchanged (points to the offending jump/branch). No compressed ISA, so bit1 must be 0.
    - Otherwise pc<=target, instr<=NOP_INSTR, go to FETCH.
  - ecall takes priority over the misaligned check.
- HALT:
  - Terminal until reset: imem_req=0, instr_valid=0, pc and instret frozen.
  - Any imem_ack in HALT or BOOT is ignored.
- Invariants and timing:
  - pc_plus4 = pc+4 combinationally at all times.
  - instr_valid is never high outside EXEC.
  - Minimum two cycles per instruction: FETCH with zero-wait ack, then EXEC.
- Reset mid-FETCH drops imem_req the same instant; the bus must tolerate an abandoned request.

Test Plan:
- Reset with RESET_PC=0x1000, zero-wait ack on every req -> BOOT one cycle, then imem_addr=0x1000; instr_valid alternates 0/1; pc advances 0x1000, 0x1004, 0x1008; after 3 retirements instret=3.
- Ack delayed 3 cycles in FETCH -> imem_req and imem_addr=0x1004 stable for 4 cycles; instr_valid=0 throughout; EXEC on the cycle after ack.
- EXEC at pc=0x2000 with pc_src=01, imm_ext=-8 -> next imem_addr=0x1FF8. Same with pc_src=11, alu_result=0x3005 -> imem_addr=0x3004.
- pc_src=01, imm_ext=0x6 at pc=0x2000 -> fault=1, fault_cause=10, halted=1, pc stays 0x2000, no further req.
- ecall=1 during EXEC with exec_stall=1 for 2 cycles -> instr_valid high 3 cycles, then halted=1, instret incremented once. imem_err=1 with ack -> fault_cause=01.
- Assert reset while in FETCH awaiting ack -> imem_req falls immediately; a late ack during BOOT is ignored; fetch restarts at RESET_PC.
